pipelined_logic_unit: RTL and testbench
=======================================

PIPELINED_LOGIC_UNIT -- requirements
Module: pipelined_logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input beat valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept an input beat this cycle.
REQ-007 SHALL have port in_a  input  WIDTH  operand A.
REQ-008 SHALL have port in_b  input  WIDTH  operand B.
REQ-009 SHALL have port in_op  input  3  operation select (see REQ-014).
REQ-010 SHALL have port in_acc  input  1  chain mode: use the accumulator instead of in_a as operand A.
REQ-011 SHALL have port out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-012 SHALL have port out_result  output  WIDTH, plus out_zero  output  1 (result all zeros) and out_parity  output  1 (XOR-reduction of result).
REQ-013 SHALL have port op_count  output  CNT_W  number of results delivered, wraps modulo 2^CNT_W.

Function
REQ-014 Opcodes SHALL be: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 NOT A, 111 PASS A; all bitwise over WIDTH bits; B is ignored for 110/111.
REQ-015 Input beat SHALL be accepted on a cycle where in_valid=1 and in_ready=1; a cycle with in_valid=1 and in_ready=0 SHALL be ignored, and the source holds its data.
REQ-016 Pipeline SHALL have two register stages: S1 (captures a, b, op, acc flag) and S2 (result, zero, parity).
REQ-017 Advance condition: adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready SHALL equal adv1 (combinational, no dependency on in_valid).
REQ-018 Result SHALL be computed combinationally from S1 contents and loaded into S2 when s1_valid & adv2.
REQ-019 Latency SHALL be 2 cycles: a beat accepted at edge N produces out_valid=1 after edge N+1 when the output is not stalled.
REQ-020 Throughput SHALL be one beat per cycle while out_ready=1 continuously; no bubbles.
REQ-021 While out_valid=1 and out_ready=0, out_result/out_zero/out_parity SHALL remain stable; S1 SHALL still fill if empty (2 beats buffered max).
REQ-022 Accumulator acc (WIDTH bits) SHALL be loaded with each result at the same edge that result enters S2.
REQ-023 With S1 acc flag =1, operand A SHALL be acc as of the S1-to-S2 transfer, i.e. the result of the immediately preceding beat in order, regardless of whether that beat has left S2.
REQ-024 op_count SHALL increment by 1 on every edge where out_valid & out_ready; wraps from 2^CNT_W-1 to 0.
REQ-025 S1 and S2 SHALL advance simultaneously in one cycle when both are full and out_ready=1, with no beat loss or duplication.
REQ-026 Zero-width or illegal opcode values SHALL not exist: all 8 codes are defined.

Reset
REQ-027 While rst=1: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_zero=1, out_parity=0, acc=0, op_count=0, asynchronously, independent of clk.
REQ-028 in_ready SHALL be 1 during and immediately after reset.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight beats; no output beat issues for them after deassertion.

Verification
REQ-030 WIDTH=32, out_ready=1: send A=F0F0F0F0, B=FF00FF00 with ops 000..111 back-to-back -> results F000F000, FFF0FFF0, 0FF00FF0, 000F000F, 0FFF0FFF, F00FF00F, 0F0F0F0F, F0F0F0F0, one per cycle starting 2 cycles after first accept; op_count=8.
REQ-031 Chain: beat1 op=111 A=0000FFFF; beat2 in_acc=1 op=010 B=FFFFFFFF; beat3 in_acc=1 op=000 B=00FF00FF -> results 0000FFFF, FFFF0000, 00FF0000.
REQ-032 Backpressure: out_ready=0 for 5 cycles with continuous in_valid -> exactly 2 beats accepted, in_ready=0 thereafter, out_result stable; release -> beats delivered in order, none lost.
REQ-033 Flags: A=B=12345678 op=010 -> out_result=0, out_zero=1, out_parity=0; A=00000001 op=111 -> out_zero=0, out_parity=1.
REQ-034 CNT_W=4: deliver 17 beats -> op_count=1 (wrap).
REQ-035 Assert rst between clock edges with both stages full -> out_valid=0 and acc=0 immediately; after release no stale beat appears and the next chain op uses acc=0.

Source files
------------

// File: rtl/pipelined_logic_unit.sv
// rtl/pipelined_logic_unit.sv - two-stage pipelined bitwise logic unit with accumulator chaining
//
// Purpose: applies one of eight bitwise operations to (A, B). Operand A can
// come from the accumulator, which holds the result of the previous beat.
// The unit has a valid/ready handshake on both sides and two register stages.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   in_valid/in_ready        input beat handshake
//   in_a, in_b, in_op        operands and opcode (000 AND .. 111 PASS A)
//   in_acc                   use the accumulator as operand A
//   out_valid/out_ready      output beat handshake
//   out_result               result of the operation
//   out_zero, out_parity     result is all zeros; XOR reduction of the result
//   op_count                 results delivered, modulo 2^CNT_W
module pipelined_logic_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  // Stage 1: captured operands
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_acc;

  // Stage 2: result and flags
  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_parity;

  logic [WIDTH-1:0] acc;

  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] res;

  // A stage may load when it is empty or its content moves on this cycle.
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // acc always holds the result of the beat just ahead of S1, because every
  // result is written into acc at the same edge it enters S2.
  assign op_a = s1_acc ? acc : s1_a;

  always_comb begin
    res = '0;
    case (s1_op)
      OP_AND:  res = op_a & s1_b;
      OP_OR:   res = op_a | s1_b;
      OP_XOR:  res = op_a ^ s1_b;
      OP_NOR:  res = ~(op_a | s1_b);
      OP_NAND: res = ~(op_a & s1_b);
      OP_XNOR: res = ~(op_a ^ s1_b);
      OP_NOTA: res = ~op_a;
      OP_PASS: res = op_a;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_acc   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_op  <= in_op;
        s1_acc <= in_acc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b1;
      s2_parity <= 1'b0;
      acc       <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= res;
        s2_zero   <= (res == '0);
        s2_parity <= ^res;
        acc       <= res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (s2_valid && out_ready) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_zero   = s2_zero;
  assign out_parity = s2_parity;

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// tb/tb_pipelined_logic_unit.sv - directed self-checking bench for pipelined_logic_unit
module tb_pipelined_logic_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic             in_acc = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_parity;
  logic [15:0]      op_count;

  logic             in_ready4;
  logic             out_valid4;
  logic [WIDTH-1:0] out_result4;
  logic             out_zero4;
  logic             out_parity4;
  logic [3:0]       op_count4;

  int checks = 0;
  int failures = 0;

  pipelined_logic_unit #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_parity(out_parity),
    .op_count(op_count)
  );

  pipelined_logic_unit #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_result(out_result4), .out_zero(out_zero4), .out_parity(out_parity4),
    .op_count(op_count4)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input logic acc_sel);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_acc   = acc_sel;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    set_in(1'b0, '0, '0, 3'b000, 1'b0);
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_zero !== 1'b1 || out_parity !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b result=%h zero=%b parity=%b, required 0 00000000 1 0",
               out_valid, out_result, out_zero, out_parity);
    end
    checks++;
    if (op_count !== 16'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_count_ready: op_count=%0d in_ready=%b, required 0 1", op_count, in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_all_ops();
    logic [WIDTH-1:0] exp_res [8];
    exp_res = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F,
                32'h0FFF0FFF, 32'hF00FF00F, 32'h0F0F0F0F, 32'hF0F0F0F0};
    reset_dut();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 10) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp_res[c-2]) begin
          failures++;
          $display("FAIL op_%0d: valid=%b result=%h, required 1 %h", c - 2, out_valid, out_result, exp_res[c-2]);
        end
      end
      if (c < 8) begin
        set_in(1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 3'(c), 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL ops_in_ready_%0d: got %b required 1", c, in_ready);
        end
      end else begin
        set_in(1'b0, '0, '0, 3'b000, 1'b0);
      end
      if (c == 10) begin
        checks++;
        if (out_valid !== 1'b0 || op_count !== 16'd8) begin
          failures++;
          $display("FAIL ops_drain: out_valid=%b op_count=%0d, required 0 8", out_valid, op_count);
        end
      end
    end
  endtask

  task automatic test_chain();
    logic [WIDTH-1:0] exp_res [3];
    exp_res = '{32'h0000FFFF, 32'hFFFF0000, 32'h00FF0000};
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp_res[c-2]) begin
          failures++;
          $display("FAIL chain_%0d: valid=%b result=%h, required 1 %h", c - 2, out_valid, out_result, exp_res[c-2]);
        end
      end
      case (c)
        0: set_in(1'b1, 32'h0000FFFF, 32'h12345678, 3'b111, 1'b0);
        1: set_in(1'b1, 32'hDEADBEEF, 32'hFFFFFFFF, 3'b010, 1'b1);
        2: set_in(1'b1, 32'hDEADBEEF, 32'h00FF00FF, 3'b000, 1'b1);
        default: set_in(1'b0, '0, '0, 3'b000, 1'b0);
      endcase
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] next_id;
    logic [WIDTH-1:0] rec [$];
    int accepted;
    next_id  = 32'd100;
    accepted = 0;
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      set_in(1'b1, next_id, '0, 3'b111, 1'b0);
      #1;
      if (in_ready) begin
        accepted++;
        next_id++;
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd100) begin
          failures++;
          $display("FAIL stall_stable_%0d: valid=%b result=%h, required 1 00000064", c, out_valid, out_result);
        end
      end
    end
    checks++;
    if (accepted != 2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_accept: accepted=%0d in_ready=%b, required 2 0", accepted, in_ready);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (next_id < 32'd105) set_in(1'b1, next_id, '0, 3'b111, 1'b0);
      else set_in(1'b0, '0, '0, 3'b000, 1'b0);
      #1;
      if (out_valid) rec.push_back(out_result);
      if (in_valid && in_ready) next_id++;
    end
    checks++;
    if (rec.size() != 5) begin
      failures++;
      $display("FAIL release_count: delivered=%0d required 5", rec.size());
    end
    for (int i = 0; i < 5 && i < rec.size(); i++) begin
      checks++;
      if (rec[i] !== 32'd100 + 32'(i)) begin
        failures++;
        $display("FAIL release_order_%0d: got %h required %h", i, rec[i], 32'd100 + 32'(i));
      end
    end
  endtask

  task automatic test_flags();
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== '0 || out_zero !== 1'b1 || out_parity !== 1'b0) begin
          failures++;
          $display("FAIL flags_zero: valid=%b result=%h zero=%b parity=%b, required 1 00000000 1 0",
                   out_valid, out_result, out_zero, out_parity);
        end
      end
      if (c == 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h1 || out_zero !== 1'b0 || out_parity !== 1'b1) begin
          failures++;
          $display("FAIL flags_one: valid=%b result=%h zero=%b parity=%b, required 1 00000001 0 1",
                   out_valid, out_result, out_zero, out_parity);
        end
      end
      case (c)
        0: set_in(1'b1, 32'h12345678, 32'h12345678, 3'b010, 1'b0);
        1: set_in(1'b1, 32'h00000001, 32'hFFFFFFFF, 3'b111, 1'b0);
        default: set_in(1'b0, '0, '0, 3'b000, 1'b0);
      endcase
    end
  endtask

  task automatic test_count_wrap();
    reset_dut();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 18) begin
        checks++;
        if (out_valid4 !== 1'b1 || out_result4 !== 32'd16 || out_zero4 !== 1'b0 || out_parity4 !== 1'b1) begin
          failures++;
          $display("FAIL wrap_last_beat: valid=%b result=%h zero=%b parity=%b, required 1 00000010 0 1",
                   out_valid4, out_result4, out_zero4, out_parity4);
        end
      end
      if (c < 17) set_in(1'b1, 32'(c), '0, 3'b111, 1'b0);
      else set_in(1'b0, '0, '0, 3'b000, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (op_count4 !== 4'd1 || in_ready4 !== 1'b1) begin
      failures++;
      $display("FAIL count_wrap: op_count=%0d in_ready=%b, required 1 1", op_count4, in_ready4);
    end
    checks++;
    if (op_count !== 16'd17) begin
      failures++;
      $display("FAIL count_17: op_count=%0d required 17", op_count);
    end
  endtask

  task automatic test_reset_midflight();
    int stray;
    stray = 0;
    reset_dut();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      case (c)
        0: set_in(1'b1, 32'hAAAA5555, '0, 3'b111, 1'b0);
        1: set_in(1'b1, 32'h12340000, '0, 3'b111, 1'b0);
        default: set_in(1'b0, '0, '0, 3'b000, 1'b0);
      endcase
    end
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut.acc !== 32'hAAAA5555) begin
      failures++;
      $display("FAIL mid_full: out_valid=%b in_ready=%b acc=%h, required 1 0 aaaa5555", out_valid, in_ready, dut.acc);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dut.acc !== '0 || out_result !== '0 || in_ready !== 1'b1 || op_count !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset: out_valid=%b acc=%h result=%h in_ready=%b op_count=%0d, required 0 0 0 1 0",
               out_valid, dut.acc, out_result, in_ready, op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL stale_beats: %0d output cycles seen, required 0", stray);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h0000000F) begin
          failures++;
          $display("FAIL chain_after_reset: valid=%b result=%h, required 1 0000000f", out_valid, out_result);
        end
      end
      if (c == 0) set_in(1'b1, 32'hFFFFFFFF, 32'h0000000F, 3'b001, 1'b1);
      else set_in(1'b0, '0, '0, 3'b000, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_all_ops();
    test_chain();
    test_backpressure();
    test_flags();
    test_count_wrap();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
